// File: rtl/song_sequencer.sv
// song_sequencer: playback controller stepping note_addr through the selected
// song at a fixed note period, forwarding each note to the buzzer with a
// trailing silent gap. Handles play, pause (toggle), stop and song change.
// Optional feature macro: LOOP_SONG_EN -- when defined, the song wraps to
// note 0 after the last note instead of entering DONE.
module song_sequencer #(
  parameter int unsigned TICKS_PER_NOTE = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000,
  parameter int unsigned SONG_LEN       = 28,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned NOTE_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        song_select,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic [NOTE_W-1:0] note_in,
  output logic [ADDR_W-1:0] note_addr,
  output logic [1:0]        song_id,
  output logic [NOTE_W-1:0] note_out,
  output logic              playing,
  output logic              paused,
  output logic              done
);

  localparam int unsigned TICK_W = (TICKS_PER_NOTE > 2) ? $clog2(TICKS_PER_NOTE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_NOTE - 1);
  localparam logic [TICK_W-1:0] GATE_END  = TICK_W'(TICKS_PER_NOTE - GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick, tick_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [1:0]          song_nxt;
  logic [NOTE_W-1:0]   note_nxt;
  logic                song_chg;
  logic                gate_open;

  // Song change and note gate decoded from current registered state
  always_comb begin
    song_chg  = (song_select != song_id);
    // tick 0 is the fetch cycle; the last GAP_TICKS ticks are silent
    gate_open = (tick != '0) && (tick < GATE_END);
  end

  // State register plus the counters, song id, note and decoded status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      note_addr <= '0;
      song_id   <= song_select;
      note_out  <= '0;
      playing   <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick      <= tick_nxt;
      note_addr <= addr_nxt;
      song_id   <= song_nxt;
      note_out  <= note_nxt;
      playing   <= (state_nxt == PLAY);
      paused    <= (state_nxt == PAUSE);
      done      <= (state_nxt == DONE);
    end
  end

  // Next-state, counter and note selection with priority stop > play > pause
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick;
    addr_nxt  = note_addr;
    song_nxt  = song_id;
    note_nxt  = '0;

    if (stop) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      addr_nxt  = '0;
      song_nxt  = song_select;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          song_nxt = song_select;
          if (play) begin
            state_nxt = PLAY;
            tick_nxt  = '0;
            addr_nxt  = '0;
          end
        end

        PLAY: begin
          if (song_chg) begin
            // Restart the new song from the top; a coincident pause still applies
            song_nxt = song_select;
            tick_nxt = '0;
            addr_nxt = '0;
            if (pause && !play) state_nxt = PAUSE;
          end else if (pause && !play) begin
            state_nxt = PAUSE;
          end else begin
            if (gate_open) note_nxt = note_in;
            if (tick == TICK_LAST) begin
              tick_nxt = '0;
              if (note_addr < ADDR_LAST) begin
                addr_nxt = note_addr + 1'b1;
              end else begin
`ifdef LOOP_SONG_EN
                addr_nxt = '0;
`else
                state_nxt = DONE;
                note_nxt  = '0;
`endif
              end
            end else begin
              tick_nxt = tick + 1'b1;
            end
          end
        end

        PAUSE: begin
          if (song_chg) begin
            song_nxt = song_select;
            tick_nxt = '0;
            addr_nxt = '0;
          end
          // Resume without advancing tick; counting continues next cycle
          if (play || pause) state_nxt = PLAY;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table-driven cycle vectors with a scoreboard queue for
// song_sequencer at a reduced note period (4 ticks, 1 gap tick, 4 notes).
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] song_select = 2'd1;
  logic       play = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [1:0] note_addr;
  logic [1:0] song_id;
  logic [3:0] note_out;
  logic       playing, paused, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst, play, pause, stop;
    logic [1:0] sel;
    logic [1:0] addr;
    logic [3:0] note;
    logic [1:0] song;
    logic       playing, paused, done;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  song_sequencer #(
    .TICKS_PER_NOTE(4),
    .GAP_TICKS     (1),
    .SONG_LEN      (4),
    .ADDR_W        (2),
    .NOTE_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .song_select(song_select),
    .play       (play),
    .pause      (pause),
    .stop       (stop),
    .note_in    (note_in),
    .note_addr  (note_addr),
    .song_id    (song_id),
    .note_out   (note_out),
    .playing    (playing),
    .paused     (paused),
    .done       (done)
  );

  // Library model: note code is address+1, one cycle after the address
  always @(posedge clk) note_in <= {2'b00, note_addr} + 4'd1;

  function automatic vec_t mk(input logic r, input logic pl_in, input logic pa_in,
                              input logic st_in, input logic [1:0] sel,
                              input logic [1:0] addr, input logic [3:0] note,
                              input logic [1:0] song, input logic pl,
                              input logic pa, input logic dn);
    vec_t v;
    v.rst = r; v.play = pl_in; v.pause = pa_in; v.stop = st_in; v.sel = sel;
    v.addr = addr; v.note = note; v.song = song;
    v.playing = pl; v.paused = pa; v.done = dn;
    return v;
  endfunction

  // Expected outputs i cycles after entering PLAY at note 0, tick 0:
  // the note is audible while tick is 2..3 (fetch + register, then 1 gap tick)
  function automatic vec_t run_at(input int i, input logic [1:0] sel,
                                  input logic pl_in, input logic pa_in);
    int t;
    int a;
    logic [3:0] n;
    t = i % 4;
    a = (i / 4) % 4;
    n = (t >= 2) ? 4'(a + 1) : 4'd0;
    return mk(1'b0, pl_in, pa_in, 1'b0, sel, 2'(a), n, sel, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst         = v.rst;
    play        = v.play;
    pause       = v.pause;
    stop        = v.stop;
    song_select = v.sel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    play  = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard vec %0d: got empty queue, expected an entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("note_addr", idx, 32'(note_addr), 32'(e.addr));
      chk("note_out",  idx, 32'(note_out),  32'(e.note));
      chk("song_id",   idx, 32'(song_id),   32'(e.song));
      chk("playing",   idx, 32'(playing),   32'(e.playing));
      chk("paused",    idx, 32'(paused),    32'(e.paused));
      chk("done",      idx, 32'(done),      32'(e.done));
    end
  endtask

  initial begin
    // Reset: song_id follows song_select while everything else is cleared
    tbl.push_back(mk(1, 0, 0, 0, 2'd1, 0, 0, 2'd1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
    // Full song: 4 notes x 4 ticks, notes 1..4 audible for 2 cycles each
    for (int i = 0; i < 16; i++) tbl.push_back(run_at(i, 2'd0, i == 0, 1'b0));
`ifdef LOOP_SONG_EN
    // Wraps to note 0 and never reaches DONE over 40 cycles
    for (int i = 16; i < 40; i++) tbl.push_back(run_at(i, 2'd0, 1'b0, 1'b0));
`else
    // End of song: DONE, silent, address parked on the last note
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 2'd3, 0, 2'd0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 2'd3, 0, 2'd0, 0, 0, 1));
    tbl.push_back(run_at(0, 2'd0, 1'b1, 1'b0));
    tbl.push_back(run_at(1, 2'd0, 1'b0, 1'b0));
`endif
    // Stop rewinds to IDLE
    tbl.push_back(mk(0, 0, 0, 1, 2'd0, 0, 0, 2'd0, 0, 0, 0));
    // play+pause from IDLE: play wins; a lone play in PLAY is ignored
    tbl.push_back(run_at(0, 2'd0, 1'b1, 1'b1));
    for (int i = 1; i <= 6; i++) tbl.push_back(run_at(i, 2'd0, i == 1, 1'b0));
    // Pause at note 1, tick 2; hold 10 cycles
    tbl.push_back(mk(0, 0, 1, 0, 2'd0, 2'd1, 0, 2'd0, 0, 1, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 0, 2'd0, 0, 1, 0));
    // Resume (play+pause together) at frozen tick 2; note re-sounds next cycle
    tbl.push_back(mk(0, 1, 1, 0, 2'd0, 2'd1, 0, 2'd0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd0, 2'd1, 4'd2, 2'd0, 1, 0, 0));
    for (int i = 8; i <= 10; i++) tbl.push_back(run_at(i, 2'd0, 1'b0, 1'b0));
    // Song change 0->2 at note 2 restarts from note 0 and keeps playing
    for (int i = 0; i <= 5; i++) tbl.push_back(run_at(i, 2'd2, 1'b0, 1'b0));
    // stop+pause together: stop wins, not paused
    tbl.push_back(mk(0, 0, 1, 1, 2'd2, 0, 0, 2'd2, 0, 0, 0));
    // Replay then reset mid-note
    for (int i = 0; i <= 2; i++) tbl.push_back(run_at(i, 2'd2, i == 0, 1'b0));
    tbl.push_back(mk(1, 0, 0, 0, 2'd2, 0, 0, 2'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2'd2, 0, 0, 2'd2, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
